// File: rtl/ydemux2_stream_if.sv
// ydemux2_stream_if: input stream, two output streams and routed-word counters of the 1-to-2 demultiplexer
interface ydemux2_stream_if #(
    parameter int W    = 8,
    parameter int CNTW = 4
);
    logic            s_valid;
    logic            s_ready;
    logic [W-1:0]    s_data;
    logic            s_sel;
    logic            m0_valid;
    logic            m0_ready;
    logic [W-1:0]    m0_data;
    logic            m1_valid;
    logic            m1_ready;
    logic [W-1:0]    m1_data;
    logic [CNTW-1:0] cnt0;
    logic [CNTW-1:0] cnt1;

    modport master (
        output s_valid, s_data, s_sel, m0_ready, m1_ready,
        input  s_ready, m0_valid, m0_data, m1_valid, m1_data, cnt0, cnt1
    );

    modport slave (
        input  s_valid, s_data, s_sel, m0_ready, m1_ready,
        output s_ready, m0_valid, m0_data, m1_valid, m1_data, cnt0, cnt1
    );
endinterface

// File: rtl/ydemux2_stream.sv
// ydemux2_stream: registered 1-to-2 stream demultiplexer with one-word holding register and wrapping counter per port
module ydemux2_stream #(
    parameter int W    = 8,
    parameter int CNTW = 4
) (
    input logic             clk,
    input logic             reset,
    ydemux2_stream_if.slave bus
);
    logic [1:0]      r_full;
    logic [W-1:0]    r_data [2];
    logic [CNTW-1:0] r_cnt  [2];
    logic            w_ready;
    logic [1:0]      w_load;
    logic [1:0]      w_drain;

    // readiness looks only at the selected port, never at s_valid, so no valid-to-ready loop exists
    always_comb begin
        w_ready = bus.s_sel ? (~r_full[1] | bus.m1_ready) : (~r_full[0] | bus.m0_ready);
        w_load  = (bus.s_valid & w_ready) ? (bus.s_sel ? 2'b10 : 2'b01) : 2'b00;
        w_drain = {bus.m1_ready, bus.m0_ready};
    end

    // load wins over drain so a same-edge swap keeps the port full at one word per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= '0;
            for (int k = 0; k < 2; k++) begin
                r_data[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= bus.s_data;
                    r_full[k] <= 1'b1;
                end else if (w_drain[k]) begin
                    r_full[k] <= 1'b0;
                end
                r_cnt[k] <= r_cnt[k] + CNTW'(w_load[k]);
            end
        end
    end

    assign bus.s_ready  = w_ready;
    assign bus.m0_valid = r_full[0];
    assign bus.m0_data  = r_data[0];
    assign bus.m1_valid = r_full[1];
    assign bus.m1_data  = r_data[1];
    assign bus.cnt0     = r_cnt[0];
    assign bus.cnt1     = r_cnt[1];
endmodule
